map_mem_arb: RTL and testbench
==============================

MAP_MEM_ARB -- requirements
Module: map_mem_arb

Interface
REQ-001 Parameter MEM_LAT, default 2: memory access duration in clk cycles; legal range 1..7.
REQ-002 Parameter MCU_MAX_WAIT, default 15: maximum number of CPU grants issued while an MCU request is pending; legal range 1..255.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  cartridge-bus access active (level, held for the whole 68k cycle).
REQ-006 cpu_addr  in  23  CPU word address.
REQ-007 cpu_we  in  2  CPU byte write strobes {hi,lo}; 0 = read.
REQ-008 cpu_di  in  16  CPU write data.
REQ-009 cpu_do  out  16  CPU read data, valid while cpu_rdy=1.
REQ-010 cpu_rdy  out  1  CPU access done; feeds dtack.
REQ-011 mcu_req  in  1  MCU/save-state request (level).
REQ-012 mcu_addr  in  23 ; mcu_we  in  2 ; mcu_di  in  16 : MCU address, byte strobes and write data.
REQ-013 mcu_ack  out  1  one-cycle pulse, MCU access done.
REQ-014 mcu_do  out  16  MCU read data, valid in the mcu_ack cycle.
REQ-015 mem_addr  out  23 ; mem_di  out  16 ; mem_oe  out  1 ; mem_we_lo  out  1 ; mem_we_hi  out  1 : shared memory port.
REQ-016 mem_do  in  16  memory read data.

Function
REQ-017 The FSM SHALL have four states: IDLE, CPU_ACC, MCU_ACC and RECOVER.
REQ-018 IDLE arbitration SHALL grant the CPU if cpu_req=1 and starve_cnt<MCU_MAX_WAIT.
REQ-019 Otherwise IDLE SHALL grant the MCU if mcu_req=1; with no request the FSM SHALL stay in IDLE.
REQ-020 The address, strobes and write data of the granted requester SHALL be latched at grant; they SHALL drive mem_addr/mem_di from the next cycle for exactly MEM_LAT cycles.
REQ-021 During an access, mem_oe SHALL be 1 when the latched strobes are 0, and mem_we_hi/mem_we_lo SHALL equal the latched strobes; all three SHALL be 0 in IDLE and RECOVER.
REQ-022 A 3-bit counter SHALL time the access; mem_do SHALL be sampled in the last access cycle.
REQ-023 CPU_ACC end: cpu_do SHALL be loaded and cpu_rdy set to 1.
REQ-024 cpu_rdy SHALL stay 1 until cpu_req=0, then the FSM SHALL go to RECOVER.
REQ-025 If cpu_req falls mid-access, the memory access SHALL still complete, cpu_rdy SHALL stay 0, and the FSM SHALL go to RECOVER.
REQ-026 MCU_ACC end: mcu_do SHALL be loaded, mcu_ack SHALL pulse for 1 cycle, and the FSM SHALL go to RECOVER.
REQ-027 mcu_req dropping mid-access SHALL have no effect on that access.
REQ-028 RECOVER SHALL last exactly 1 cycle with the memory port idle, then return to IDLE.
REQ-029 A new CPU grant SHALL not occur until cpu_req has been seen low (one grant per bus cycle).
REQ-030 starve_cnt (8 bit) SHALL increment on each CPU grant while mcu_req=1, saturating at MCU_MAX_WAIT.
REQ-031 starve_cnt SHALL clear on an MCU grant, or on any cycle with mcu_req=0.
REQ-032 Simultaneous cpu_req and mcu_req in IDLE: the CPU SHALL win unless starve_cnt=MCU_MAX_WAIT, in which case the MCU SHALL win and the CPU SHALL wait.
REQ-033 A request arriving during RECOVER SHALL be arbitrated in the following IDLE cycle.
REQ-034 An MCU requester holding mcu_req after mcu_ack SHALL receive a new access (back-to-back, one per MEM_LAT+2 cycles).
REQ-035 CPU grant latency SHALL be 1 cycle from cpu_req seen in IDLE; cpu_rdy SHALL rise MEM_LAT+1 cycles after grant.

Reset
REQ-036 sys_rst_n=0 SHALL asynchronously set state to IDLE and clear the counters, starve_cnt and the cpu-seen-low flag.
REQ-037 sys_rst_n=0 SHALL drive cpu_rdy, mcu_ack, mem_oe, mem_we_hi and mem_we_lo to 0, and cpu_do, mcu_do, mem_addr and mem_di to 0.
REQ-038 Reset asserted mid-access SHALL abort the access immediately, with no ack and no rdy.
REQ-039 After reset release, the first arbitration SHALL occur in the first clk edge with sys_rst_n=1.

Verification
REQ-040 CPU read: cpu_addr=0x000100, mem_do=0xBEEF at access end -> mem_oe=1 for 2 cycles, cpu_rdy=1, cpu_do=0xBEEF until cpu_req drops, then 1 RECOVER cycle.
REQ-041 MCU write: mcu_addr=0x700000, mcu_we=2'b01, mcu_di=0x1234 -> mem_we_lo=1, mem_we_hi=0 for 2 cycles, mem_di=0x1234, mcu_ack single pulse.
REQ-042 Starvation: mcu_req held while cpu_req toggles continuously -> exactly 15 CPU grants, then 1 MCU grant; starve_cnt back to 0.
REQ-043 Simultaneous cpu_req/mcu_req from reset -> CPU granted first, MCU granted in the IDLE after the CPU RECOVER if cpu_req is low.
REQ-044 cpu_req dropped 1 cycle after grant -> access completes, cpu_rdy never 1, FSM reaches IDLE after RECOVER.
REQ-045 sys_rst_n pulsed low during MCU_ACC -> all outputs 0 at once, no mcu_ack; a held mcu_req is re-granted after release.

Source files
------------

// File: rtl/map_mem_arb.sv
// Arbiter sharing one memory port between the 68k cartridge bus and the MCU/save-state engine.
// The CPU wins by default, and a starvation counter forces an MCU slot after MCU_MAX_WAIT CPU grants.
module map_mem_arb #(
    parameter int MEM_LAT      = 2,
    parameter int MCU_MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        cpu_req,
    input  logic [22:0] cpu_addr,
    input  logic [1:0]  cpu_we,
    input  logic [15:0] cpu_di,
    output logic [15:0] cpu_do,
    output logic        cpu_rdy,
    input  logic        mcu_req,
    input  logic [22:0] mcu_addr,
    input  logic [1:0]  mcu_we,
    input  logic [15:0] mcu_di,
    output logic        mcu_ack,
    output logic [15:0] mcu_do,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_di,
    output logic        mem_oe,
    output logic        mem_we_lo,
    output logic        mem_we_hi,
    input  logic [15:0] mem_do
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, MCU_ACC, RECOVER} state_t;

    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);
    localparam logic [7:0] MAX_WAIT = 8'(MCU_MAX_WAIT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  starve_q, starve_d;
    logic        cpu_block_q, cpu_block_d;
    logic [22:0] addr_q, addr_d;
    logic [1:0]  we_q, we_d;
    logic [15:0] di_q, di_d;
    logic [15:0] cpu_do_q, cpu_do_d;
    logic [15:0] mcu_do_q, mcu_do_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        mcu_ack_q, mcu_ack_d;
    logic        cpu_grant, mcu_grant;
    logic        mem_active;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        di_d        = di_q;
        cpu_do_d    = cpu_do_q;
        mcu_do_d    = mcu_do_q;
        cpu_rdy_d   = cpu_rdy_q;
        mcu_ack_d   = 1'b0;
        cpu_grant   = 1'b0;
        mcu_grant   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req && !cpu_block_q && (starve_q < MAX_WAIT)) begin
                    cpu_grant = 1'b1;
                    state_d   = CPU_ACC;
                    cnt_d     = 3'd0;
                    addr_d    = cpu_addr;
                    we_d      = cpu_we;
                    di_d      = cpu_di;
                end else if (mcu_req) begin
                    mcu_grant = 1'b1;
                    state_d   = MCU_ACC;
                    cnt_d     = 3'd0;
                    addr_d    = mcu_addr;
                    we_d      = mcu_we;
                    di_d      = mcu_di;
                end
            end
            CPU_ACC: begin
                // Once cpu_rdy is up the memory access is over; we only wait for the bus cycle to end.
                if (cpu_rdy_q) begin
                    if (!cpu_req) begin
                        cpu_rdy_d = 1'b0;
                        state_d   = RECOVER;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    cpu_do_d = mem_do;
                    if (cpu_req) begin
                        cpu_rdy_d = 1'b1;
                    end else begin
                        state_d = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            MCU_ACC: begin
                if (cnt_q == LAST_CNT) begin
                    mcu_do_d  = mem_do;
                    mcu_ack_d = 1'b1;
                    state_d   = RECOVER;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // One grant per 68k bus cycle: block re-grant until cpu_req has been observed low.
        cpu_block_d = cpu_block_q;
        if (cpu_grant) begin
            cpu_block_d = 1'b1;
        end else if (!cpu_req) begin
            cpu_block_d = 1'b0;
        end

        starve_d = starve_q;
        if (!mcu_req || mcu_grant) begin
            starve_d = 8'd0;
        end else if (cpu_grant && (starve_q < MAX_WAIT)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            starve_q    <= 8'd0;
            cpu_block_q <= 1'b0;
            addr_q      <= 23'd0;
            we_q        <= 2'd0;
            di_q        <= 16'd0;
            cpu_do_q    <= 16'd0;
            mcu_do_q    <= 16'd0;
            cpu_rdy_q   <= 1'b0;
            mcu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            cpu_block_q <= cpu_block_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            di_q        <= di_d;
            cpu_do_q    <= cpu_do_d;
            mcu_do_q    <= mcu_do_d;
            cpu_rdy_q   <= cpu_rdy_d;
            mcu_ack_q   <= mcu_ack_d;
        end
    end

    assign mem_active = (state_q == MCU_ACC) || ((state_q == CPU_ACC) && !cpu_rdy_q);

    assign mem_addr  = addr_q;
    assign mem_di    = di_q;
    assign mem_oe    = mem_active && (we_q == 2'b00);
    assign mem_we_hi = mem_active && we_q[1];
    assign mem_we_lo = mem_active && we_q[0];
    assign cpu_do    = cpu_do_q;
    assign cpu_rdy   = cpu_rdy_q;
    assign mcu_do    = mcu_do_q;
    assign mcu_ack   = mcu_ack_q;

endmodule

// File: tb/tb_map_mem_arb.sv
// Randomized bench for map_mem_arb against a transaction-level model of the arbiter.
// Also runs a held-MCU starvation scenario and random asynchronous resets.
module tb_map_mem_arb;

    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic [1:0]  cpu_we = '0;
    logic [15:0] cpu_di = '0;
    logic [15:0] cpu_do;
    logic        cpu_rdy;
    logic        mcu_req = 1'b0;
    logic [22:0] mcu_addr = '0;
    logic [1:0]  mcu_we = '0;
    logic [15:0] mcu_di = '0;
    logic        mcu_ack;
    logic [15:0] mcu_do;
    logic [22:0] mem_addr;
    logic [15:0] mem_di;
    logic        mem_oe;
    logic        mem_we_lo;
    logic        mem_we_hi;
    logic [15:0] mem_do = '0;

    map_mem_arb #(.MEM_LAT(MEM_LAT), .MCU_MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_di(cpu_di),
        .cpu_do(cpu_do), .cpu_rdy(cpu_rdy),
        .mcu_req(mcu_req), .mcu_addr(mcu_addr), .mcu_we(mcu_we), .mcu_di(mcu_di),
        .mcu_ack(mcu_ack), .mcu_do(mcu_do),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_oe(mem_oe),
        .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: who owns the port (0 none, 1 cpu, 2 mcu) and how many access cycles remain.
    int          m_owner;
    int          m_left;
    bit          m_recover;
    bit          m_rdy;
    bit          m_ack;
    bit          m_blocked;
    int          m_starve;
    logic [22:0] m_addr;
    logic [1:0]  m_we;
    logic [15:0] m_di;
    logic [15:0] m_cpu_do;
    logic [15:0] m_mcu_do;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_owner = 0; m_left = 0; m_recover = 0; m_rdy = 0; m_ack = 0;
        m_blocked = 0; m_starve = 0;
        m_addr = '0; m_we = '0; m_di = '0; m_cpu_do = '0; m_mcu_do = '0;
    endtask

    task automatic modelStep();
        bit cpu_g = 0;
        bit mcu_g = 0;
        bit ack_next = 0;
        if (m_recover) begin
            m_recover = 0;
        end else if (m_owner == 0) begin
            if (cpu_req && !m_blocked && m_starve < MAX_WAIT) begin
                cpu_g = 1; m_owner = 1; m_left = MEM_LAT;
                m_addr = cpu_addr; m_we = cpu_we; m_di = cpu_di;
            end else if (mcu_req) begin
                mcu_g = 1; m_owner = 2; m_left = MEM_LAT;
                m_addr = mcu_addr; m_we = mcu_we; m_di = mcu_di;
            end
        end else if (m_owner == 1 && m_rdy) begin
            if (!cpu_req) begin
                m_rdy = 0; m_owner = 0; m_recover = 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_owner == 1) begin
                    m_cpu_do = mem_do;
                    if (cpu_req) m_rdy = 1;
                    else begin m_owner = 0; m_recover = 1; end
                end else begin
                    m_mcu_do = mem_do; ack_next = 1; m_owner = 0; m_recover = 1;
                end
            end
        end
        m_ack = ack_next;
        if (cpu_g) m_blocked = 1;
        else if (!cpu_req) m_blocked = 0;
        if (!mcu_req || mcu_g) m_starve = 0;
        else if (cpu_g) m_starve = (m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1;
    endtask

    task automatic checkAll();
        bit active;
        active = (m_owner == 2) || (m_owner == 1 && !m_rdy);
        checkOutput("cpu_rdy", 32'(cpu_rdy), 32'(m_rdy));
        checkOutput("mcu_ack", 32'(mcu_ack), 32'(m_ack));
        checkOutput("mem_oe", 32'(mem_oe), 32'(active && m_we == 2'b00));
        checkOutput("mem_we_hi", 32'(mem_we_hi), 32'(active && m_we[1]));
        checkOutput("mem_we_lo", 32'(mem_we_lo), 32'(active && m_we[0]));
        if (active) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
            checkOutput("mem_di", 32'(mem_di), 32'(m_di));
        end
        if (m_rdy) checkOutput("cpu_do", 32'(cpu_do), 32'(m_cpu_do));
        if (m_ack) checkOutput("mcu_do", 32'(mcu_do), 32'(m_mcu_do));
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_cpu_rdy", 32'(cpu_rdy), 32'd0);
        checkOutput("rst_mcu_ack", 32'(mcu_ack), 32'd0);
        checkOutput("rst_mem_oe", 32'(mem_oe), 32'd0);
        checkOutput("rst_mem_we_hi", 32'(mem_we_hi), 32'd0);
        checkOutput("rst_mem_we_lo", 32'(mem_we_lo), 32'd0);
        checkOutput("rst_cpu_do", 32'(cpu_do), 32'd0);
        checkOutput("rst_mcu_do", 32'(mcu_do), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_di", 32'(mem_di), 32'd0);
    endtask

    // mode 0: free-running random requests; mode 1: MCU held while the CPU runs back-to-back bus cycles.
    task automatic applyStimulus(input int mode);
        cpu_addr = 23'($urandom);
        cpu_we   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
        cpu_di   = 16'($urandom);
        mcu_addr = 23'($urandom);
        mcu_we   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
        mcu_di   = 16'($urandom);
        mem_do   = 16'($urandom);
        if (mode == 0) begin
            if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
            if ($urandom_range(0, 5) == 0) mcu_req = ~mcu_req;
        end else begin
            mcu_req = 1'b1;
            cpu_req = !(cpu_req && cpu_rdy);
        end
    endtask

    task automatic pulseReset();
        sys_rst_n = 1'b0;
        #1;
        checkResetOutputs();
        modelReset();
        @(negedge clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int cpu_rises;
        bit prev_rdy;
        bit got_ack;

        modelReset();
        repeat (2) @(negedge clk);
        checkResetOutputs();

        // Both requesters raise together straight out of reset.
        cpu_req = 1'b1;
        mcu_req = 1'b1;
        sys_rst_n = 1'b1;
        applyStimulus(1);
        #1; checkAll(); modelStep();

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) pulseReset();
            applyStimulus(0);
            #1; checkAll(); modelStep();
        end

        // Starvation: from a clean reset, exactly MAX_WAIT CPU bus cycles precede the MCU slot.
        @(negedge clk);
        cpu_req = 1'b0;
        mcu_req = 1'b1;
        pulseReset();
        cpu_rises = 0;
        prev_rdy = 1'b0;
        got_ack = 1'b0;
        for (int i = 0; i < 400 && !got_ack; i++) begin
            if (i != 0) @(negedge clk);
            if (cpu_rdy && !prev_rdy) cpu_rises++;
            prev_rdy = cpu_rdy;
            if (mcu_ack) begin
                got_ack = 1'b1;
                checkOutput("starve_cpu_grants", 32'(cpu_rises), 32'(MAX_WAIT));
            end
            applyStimulus(1);
            #1; checkAll(); modelStep();
        end
        checkOutput("starve_mcu_granted", 32'(got_ack), 32'd1);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            applyStimulus(0);
            #1; checkAll(); modelStep();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
